// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, fetch strobes and IR state encoding.
package cpu8_pkg;

   localparam int unsigned OP_W    = 3;
   localparam int unsigned FETCH_W = 2;

   localparam logic [OP_W-1:0] OP_NOP = 3'b000;
   localparam logic [OP_W-1:0] OP_LDO = 3'b001;
   localparam logic [OP_W-1:0] OP_LDA = 3'b010;
   localparam logic [OP_W-1:0] OP_STO = 3'b011;
   localparam logic [OP_W-1:0] OP_PRE = 3'b100;
   localparam logic [OP_W-1:0] OP_ADD = 3'b101;
   localparam logic [OP_W-1:0] OP_LDM = 3'b110;
   localparam logic [OP_W-1:0] OP_HLT = 3'b111;

   localparam logic [FETCH_W-1:0] FETCH_NONE = 2'b00;
   localparam logic [FETCH_W-1:0] FETCH_HI   = 2'b01;
   localparam logic [FETCH_W-1:0] FETCH_LO   = 2'b10;
   localparam logic [FETCH_W-1:0] FETCH_RSV  = 2'b11;

   typedef enum logic [1:0] {
      IR_EMPTY = 2'd0,
      IR_HI    = 2'd1,
      IR_FULL  = 2'd2
   } ir_state_e;

endpackage

// File: rtl/prog_counter.sv
// Program counter: wrapping increment under enable, async reset to RESET_PC.
module prog_counter #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= ADDR_W'(RESET_PC);
      end else if (ena) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, two-byte IR assembly and ROM/RAM address mux.
module instr_fetch
   import cpu8_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         fetch,
   input  logic               pc_ena,
   input  logic               ad_sel,
   input  logic [DATA_W-1:0]  rom_data,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [ADDR_W-1:0]  pc,
   output logic [2:0]         ins,
   output logic [4:0]         reg_ad,
   output logic [DATA_W-1:0]  operand,
   output logic               ir_full,
   output logic               seq_err
);

   ir_state_e         state, state_nxt;
   logic [DATA_W-1:0] ir_hi, ir_hi_nxt;
   logic [DATA_W-1:0] ir_lo, ir_lo_nxt;
   logic              seq_err_nxt;

   prog_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk (clk),
      .rst (rst),
      .ena (pc_ena),
      .pc  (pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IR_EMPTY;
         ir_hi   <= '0;
         ir_lo   <= '0;
         ir_full <= 1'b0;
         seq_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         ir_hi   <= ir_hi_nxt;
         ir_lo   <= ir_lo_nxt;
         ir_full <= (state_nxt == IR_FULL);
         seq_err <= seq_err_nxt;
      end
   end

   // High-byte strobe during an operand read (ad_sel=1) is a data access, not an IR load.
   always_comb begin
      state_nxt   = state;
      ir_hi_nxt   = ir_hi;
      ir_lo_nxt   = ir_lo;
      seq_err_nxt = seq_err;
      case (fetch)
         FETCH_HI: begin
            if (!ad_sel) begin
               ir_hi_nxt = rom_data;
               ir_lo_nxt = '0;
               state_nxt = IR_HI;
            end
         end
         FETCH_LO: begin
            if (state == IR_EMPTY) begin
               seq_err_nxt = 1'b1;
            end else begin
               ir_lo_nxt = rom_data;
               state_nxt = IR_FULL;
            end
         end
         FETCH_RSV: seq_err_nxt = 1'b1;
         default: ;
      endcase
   end

   assign ins      = ir_hi[7:5];
   assign reg_ad   = ir_hi[4:0];
   assign operand  = ir_lo;
   assign mem_addr = ad_sel ? ADDR_W'(ir_lo) : pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue of expected output snapshots.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] fetch;
   logic       pc_ena;
   logic       ad_sel;
   logic [7:0] rom_data;
   logic [7:0] mem_addr;
   logic [7:0] pc;
   logic [2:0] ins;
   logic [4:0] reg_ad;
   logic [7:0] operand;
   logic       ir_full;
   logic       seq_err;

   typedef struct {
      string      tag;
      logic [7:0] pc;
      logic [7:0] mem_addr;
      logic [2:0] ins;
      logic [4:0] reg_ad;
      logic [7:0] operand;
      logic       ir_full;
      logic       seq_err;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   instr_fetch #(
      .ADDR_W   (8),
      .DATA_W   (8),
      .RESET_PC (0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .fetch    (fetch),
      .pc_ena   (pc_ena),
      .ad_sel   (ad_sel),
      .rom_data (rom_data),
      .mem_addr (mem_addr),
      .pc       (pc),
      .ins      (ins),
      .reg_ad   (reg_ad),
      .operand  (operand),
      .ir_full  (ir_full),
      .seq_err  (seq_err)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [7:0] e_pc, input logic [7:0] e_ma,
                       input logic [2:0] e_ins, input logic [4:0] e_reg, input logic [7:0] e_op,
                       input logic e_full, input logic e_err);
      exp_t e;
      e.tag = tag; e.pc = e_pc; e.mem_addr = e_ma; e.ins = e_ins; e.reg_ad = e_reg;
      e.operand = e_op; e.ir_full = e_full; e.seq_err = e_err;
      exp_q.push_back(e);
   endtask

   task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s.%s: got %h expected %h", tag, fld, obs, exp);
      end
   endtask

   // Pop the oldest expectation and compare it against the current outputs.
   task automatic check();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard: got empty queue expected entry");
         return;
      end
      e = exp_q.pop_front();
      cmp(e.tag, "pc",       pc,                e.pc);
      cmp(e.tag, "mem_addr", mem_addr,          e.mem_addr);
      cmp(e.tag, "ins",      8'(ins),           8'(e.ins));
      cmp(e.tag, "reg_ad",   8'(reg_ad),        8'(e.reg_ad));
      cmp(e.tag, "operand",  operand,           e.operand);
      cmp(e.tag, "ir_full",  8'(ir_full),       8'(e.ir_full));
      cmp(e.tag, "seq_err",  8'(seq_err),       8'(e.seq_err));
   endtask

   // Apply one cycle of strobes, clock it, then return inputs to idle.
   task automatic cyc(input logic [1:0] f, input logic pe, input logic as, input logic [7:0] rd);
      fetch = f; pc_ena = pe; ad_sel = as; rom_data = rd;
      @(posedge clk);
      #1;
      fetch = 2'b00; pc_ena = 1'b0; ad_sel = 1'b0; rom_data = 8'h00;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; fetch = 2'b00; pc_ena = 1'b0; ad_sel = 1'b0; rom_data = 8'h00;
      #3;
      push("reset", 8'h00, 8'h00, 3'b000, 5'h00, 8'h00, 1'b0, 1'b0);
      check();
      @(negedge clk);
      rst = 1'b0;

      // Test 1: high byte load
      cyc(2'b01, 1'b0, 1'b0, 8'hA3);
      push("hi_a3", 8'h00, 8'h00, 3'b101, 5'h03, 8'h00, 1'b0, 1'b0);
      check();

      // Test 2: full two-byte instruction with PC advance
      cyc(2'b01, 1'b0, 1'b0, 8'h45);
      push("seq_a", 8'h00, 8'h00, 3'b010, 5'h05, 8'h00, 1'b0, 1'b0);
      check();
      cyc(2'b00, 1'b1, 1'b0, 8'h00);
      push("seq_b", 8'h01, 8'h01, 3'b010, 5'h05, 8'h00, 1'b0, 1'b0);
      check();
      cyc(2'b10, 1'b0, 1'b0, 8'h7E);
      push("seq_c", 8'h01, 8'h01, 3'b010, 5'h05, 8'h7E, 1'b1, 1'b0);
      check();
      cyc(2'b10, 1'b1, 1'b0, 8'h7E);
      push("seq_d", 8'h02, 8'h02, 3'b010, 5'h05, 8'h7E, 1'b1, 1'b0);
      check();
      ad_sel = 1'b1;
      #1;
      push("addr_sel", 8'h02, 8'h7E, 3'b010, 5'h05, 8'h7E, 1'b1, 1'b0);
      check();
      ad_sel = 1'b0;

      // Test 3: operand-phase read must not disturb IR
      cyc(2'b01, 1'b0, 1'b1, 8'hFF);
      push("opnd_rd", 8'h02, 8'h02, 3'b010, 5'h05, 8'h7E, 1'b1, 1'b0);
      check();

      // Test 4: protocol errors
      do_reset();
      push("rst2", 8'h00, 8'h00, 3'b000, 5'h00, 8'h00, 1'b0, 1'b0);
      check();
      cyc(2'b10, 1'b0, 1'b0, 8'h55);
      push("lo_empty", 8'h00, 8'h00, 3'b000, 5'h00, 8'h00, 1'b0, 1'b1);
      check();
      cyc(2'b01, 1'b0, 1'b0, 8'h6C);
      push("hi_after_err", 8'h00, 8'h00, 3'b011, 5'h0C, 8'h00, 1'b0, 1'b1);
      check();
      cyc(2'b11, 1'b0, 1'b0, 8'h99);
      push("rsv_in_hi", 8'h00, 8'h00, 3'b011, 5'h0C, 8'h00, 1'b0, 1'b1);
      check();
      cyc(2'b10, 1'b0, 1'b0, 8'h21);
      push("err_sticky", 8'h00, 8'h00, 3'b011, 5'h0C, 8'h21, 1'b1, 1'b1);
      check();
      do_reset();
      push("err_clear", 8'h00, 8'h00, 3'b000, 5'h00, 8'h00, 1'b0, 1'b0);
      check();

      // Test 5: PC wrap
      for (int i = 0; i < 255; i++) cyc(2'b00, 1'b1, 1'b0, 8'h00);
      push("pc_ff", 8'hFF, 8'hFF, 3'b000, 5'h00, 8'h00, 1'b0, 1'b0);
      check();
      cyc(2'b00, 1'b1, 1'b0, 8'h00);
      push("pc_wrap", 8'h00, 8'h00, 3'b000, 5'h00, 8'h00, 1'b0, 1'b0);
      check();

      // Test 6: same-edge fetch and pc_ena, then async reset mid-instruction
      for (int i = 0; i < 17; i++) cyc(2'b00, 1'b1, 1'b0, 8'h00);
      cyc(2'b01, 1'b1, 1'b0, 8'hC4);
      push("hi_and_inc", 8'h12, 8'h12, 3'b110, 5'h04, 8'h00, 1'b0, 1'b0);
      check();
      #1;
      rst = 1'b1;
      #1;
      push("async_rst", 8'h00, 8'h00, 3'b000, 5'h00, 8'h00, 1'b0, 1'b0);
      check();
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the CPU controller.
- Holds the program counter and drives the ROM/RAM address mux.
- Assembles each instruction from two ROM bytes into the instruction register (IR), under the controller's fetch, PC_ena and ad_sel strobes.
- Supplies the controller's 3-bit opcode `ins`, plus the register address and operand byte to the datapath.

Parameters:
- ADDR_W, 8, width of the PC and memory address.
- DATA_W, 8, width of the ROM data bus and of each IR byte; fixed at 8.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch  in  2  IR load code from controller: 00 none, 01 high byte, 10 low byte, 11 reserved.
- pc_ena  in  1  increment PC at next edge.
- ad_sel  in  1  address select: 0 = PC, 1 = IR operand byte.
- rom_data  in  DATA_W  ROM read data.
- mem_addr  out  ADDR_W  ROM/RAM address, combinational: ad_sel ? ir_lo : pc.
- pc  out  ADDR_W  current program counter.
- ins  out  3  ir_hi[7:5], opcode to controller.
- reg_ad  out  5  ir_hi[4:0], register-file address.
- operand  out  DATA_W  ir_lo, memory address or immediate.
- ir_full  out  1  both IR bytes loaded for the current instruction.
- seq_err  out  1  sticky fetch-protocol error flag.

Behaviour:
Reset:
- While rst=1, asynchronously: pc=RESET_PC, ir_hi=0, ir_lo=0, IR state=EMPTY.
- Outputs during reset: ins=000 (NOP), reg_ad=0, operand=0, ir_full=0, seq_err=0.
- mem_addr=RESET_PC, since ad_sel is 0 from the idle controller.
- Reset asserted mid-instruction discards the partial IR; no other recovery.

IR state machine (EMPTY, HI, FULL), evaluated each rising edge:
- fetch=01 and ad_sel=0:
  - ir_hi<=rom_data, ir_lo<=0, state->HI, from any state.
- fetch=01 and ad_sel=1:
  - Operand-phase data read; IR and state unchanged.
  - This occurs during load-from-memory instructions and must not corrupt `ins`.
- fetch=10 in HI or FULL: ir_lo<=rom_data, state->FULL.
  - Repeated fetch=10 cycles overwrite ir_lo with the current byte (idempotent when PC is unchanged).
- fetch=10 in EMPTY: no load; seq_err<=1.
- fetch=11: no load; seq_err<=1.
- fetch=00: hold.
- seq_err clears only on reset.

Program counter:
- pc_ena=1: pc<=pc+1 modulo 2^ADDR_W; wraps all-ones->0 with no flag.
- pc_ena is independent of fetch. Same-edge pc_ena and fetch: the IR captures rom_data addressed by the pre-increment pc (registered semantics, no bypass).

Output timing:
- ins, reg_ad and operand come straight from registers; they are valid the cycle after capture.
- Example: a high byte captured in controller state S0 is visible to the controller's S1 decode.
- mem_addr is purely combinational from ad_sel, pc and ir_lo; zero-latency mux.

Decomposition:
- Shared package cpu8_pkg:
  - opcode constants NOP..HLT (000..111).
  - fetch codes FETCH_NONE=00, FETCH_HI=01, FETCH_LO=10.
  - IR state encoding EMPTY=0, HI=1, FULL=2.
- The controller also imports cpu8_pkg.
- One natural sub-module: prog_counter, containing the ADDR_W-bit counter with async reset to RESET_PC and the enable. The IR and address mux stay in instr_fetch.

Test Plan:
1. Reset then fetch=01, rom_data=0xA3 -> next cycle ins=101, reg_ad=0x03, operand=0x00, ir_full=0, seq_err=0.
2. Cycle-by-cycle sequence:
   - Cycle A: fetch=01, rom=0x45.
   - Cycle B: pc_ena=1.
   - Cycles C and D: fetch=10, rom=0x7E.
   - Cycle D: pc_ena=1.
   - Required: ins=010, operand=0x7E, ir_full=1, pc advanced by 2.
   - With ad_sel=1: mem_addr=0x7E.
3. After a full load, fetch=01 with ad_sel=1 and rom=0xFF -> ins/operand unchanged, ir_full stays 1.
4. From reset: fetch=10 -> seq_err=1, ir_full=0. Separately, fetch=11 in HI -> seq_err=1, IR unchanged. seq_err persists until rst.
5. Load pc to 0xFF via pc_ena pulses, then pc_ena=1 -> pc=0x00.
6. Assert rst mid-instruction (state HI, pc=0x12) -> immediately pc=RESET_PC, ins=000, ir_full=0, all without a clock edge.
